// File: rtl/lbu_pkg.sv
// Shared definitions for the loop-buffer pointer path: op codes, default widths
// and the pointer-context record.
package lbu_pkg;

    localparam int LBU_P_PTR    = 24;
    localparam int LBU_P_STRIDE = 8;
    localparam int LBU_P_MODE   = 3;

    localparam logic [2:0] PTR_OP_NONE = 3'd0;
    localparam logic [2:0] PTR_OP_RST  = 3'd1;
    localparam logic [2:0] PTR_OP_INCR = 3'd2;
    localparam logic [2:0] PTR_OP_DECR = 3'd3;

    typedef struct packed {
        logic [LBU_P_PTR-1:0]    start_ptr;
        logic [LBU_P_PTR-1:0]    end_ptr;
        logic [LBU_P_STRIDE-1:0] stride;
        logic [LBU_P_PTR-1:0]    ptr;
    } lbu_ctx_t;

endpackage

// File: rtl/lbu_ptr_next.sv
// Combinational next-pointer computation for one loop-buffer context
// (signed, optional wrap between start and end).
module lbu_ptr_next
    import lbu_pkg::*;
#(
    parameter int P_PTR    = LBU_P_PTR,
    parameter int P_STRIDE = LBU_P_STRIDE,
    parameter int P_MODE   = LBU_P_MODE
) (
    input  logic [P_MODE-1:0]   mode,
    input  logic                waen,
    input  logic [P_PTR-1:0]    start_ptr,
    input  logic [P_PTR-1:0]    end_ptr,
    input  logic [P_STRIDE-1:0] stride,
    input  logic [P_PTR-1:0]    ptr,
    output logic [P_PTR-1:0]    next_ptr
);

    logic signed [P_PTR-1:0] stride_ext;
    logic signed [P_PTR-1:0] t_inc;
    logic signed [P_PTR-1:0] t_dec;

    assign stride_ext = {{(P_PTR-P_STRIDE){stride[P_STRIDE-1]}}, stride};
    assign t_inc      = $signed(ptr) + stride_ext;
    assign t_dec      = $signed(ptr) - stride_ext;

    // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
    always_comb begin
        next_ptr = ptr;
        case (mode)
            P_MODE'(PTR_OP_RST):  next_ptr = start_ptr;
            P_MODE'(PTR_OP_INCR): next_ptr = (waen && (t_inc > $signed(end_ptr)))   ? start_ptr : t_inc;
            P_MODE'(PTR_OP_DECR): next_ptr = (waen && (t_dec < $signed(start_ptr))) ? end_ptr   : t_dec;
            default:              next_ptr = ptr;
        endcase
    end

endmodule

// File: rtl/lbu_ptr_ctx_file.sv
// Loop-buffer pointer context file: emits the current pointer as an address and
// commits the next one. Optional sticky bound checking via LBU_PTR_BOUND_CHECK_EN.
module lbu_ptr_ctx_file
    import lbu_pkg::*;
#(
    parameter int P_NUM_ID = 4,
    parameter int P_ID_W   = 2,
    parameter int P_STRIDE = LBU_P_STRIDE,
    parameter int P_PTR    = LBU_P_PTR,
    parameter int P_MODE   = LBU_P_MODE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_lbset,
    input  logic [P_ID_W-1:0]   cmd_id,
    input  logic [P_MODE-1:0]   cmd_mode,
    input  logic                cmd_waen,
    input  logic [P_PTR-1:0]    cmd_start,
    input  logic [P_PTR-1:0]    cmd_end,
    input  logic [P_STRIDE-1:0] cmd_stride,
    output logic                addr_valid,
    input  logic                addr_ready,
    output logic [P_ID_W-1:0]   addr_id,
    output logic [P_PTR-1:0]    addr_ptr,
    output logic                ctx_err
);

    logic [P_PTR-1:0]    ctx_start  [P_NUM_ID];
    logic [P_PTR-1:0]    ctx_end    [P_NUM_ID];
    logic [P_STRIDE-1:0] ctx_stride [P_NUM_ID];
    logic [P_PTR-1:0]    ctx_ptr    [P_NUM_ID];

    logic             accept;
    logic [P_PTR-1:0] sel_start;
    logic [P_PTR-1:0] sel_end;
    logic [P_PTR-1:0] sel_ptr;
    logic [P_PTR-1:0] next_ptr;

    assign cmd_ready = !addr_valid || addr_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign sel_start = ctx_start[cmd_id];
    assign sel_end   = ctx_end[cmd_id];
    assign sel_ptr   = ctx_ptr[cmd_id];

    lbu_ptr_next #(
        .P_PTR    (P_PTR),
        .P_STRIDE (P_STRIDE),
        .P_MODE   (P_MODE)
    ) u_next (
        .mode      (cmd_mode),
        .waen      (cmd_waen),
        .start_ptr (sel_start),
        .end_ptr   (sel_end),
        .stride    (ctx_stride[cmd_id]),
        .ptr       (sel_ptr),
        .next_ptr  (next_ptr)
    );

    // NOTE: the contexts are a handful of flops, not a RAM, so resetting them is cheap
    // and gives a defined pointer after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P_NUM_ID; i++) begin
                ctx_start[i]  <= '0;
                ctx_end[i]    <= '0;
                ctx_stride[i] <= '0;
                ctx_ptr[i]    <= '0;
            end
        end else if (accept) begin
            if (cmd_lbset) begin
                ctx_start[cmd_id]  <= cmd_start;
                ctx_end[cmd_id]    <= cmd_end;
                ctx_stride[cmd_id] <= cmd_stride;
                ctx_ptr[cmd_id]    <= cmd_start;
            end else begin
                ctx_ptr[cmd_id]    <= next_ptr;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_valid <= 1'b0;
            addr_id    <= '0;
            addr_ptr   <= '0;
        end else if (accept) begin
            addr_valid <= !cmd_lbset;
            if (!cmd_lbset) begin
                addr_id  <= cmd_id;
                addr_ptr <= sel_ptr;
            end
        end else if (addr_ready) begin
            addr_valid <= 1'b0;
        end
    end

`ifdef LBU_PTR_BOUND_CHECK_EN
    logic err_q;
    logic lbset_bad;
    logic op_bad;

    assign lbset_bad = ($signed(cmd_start) > $signed(cmd_end)) || (cmd_stride == '0);
    assign op_bad    = cmd_waen && (($signed(next_ptr) < $signed(sel_start)) ||
                                    ($signed(next_ptr) > $signed(sel_end)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && (cmd_lbset ? lbset_bad : op_bad)) begin
            err_q <= 1'b1;
        end
    end

    assign ctx_err = err_q;
`else
    assign ctx_err = 1'b0;
`endif

endmodule
